serial_pattern_checker: RTL



---
 rtl/serial_pattern_checker_pkg.sv | 17 +
 rtl/serial_pattern_checker_if.sv | 26 ++
 rtl/serial_pattern_checker_shift_window.sv | 32 +++
 rtl/serial_pattern_checker.sv | 129 ++++++++++++
 4 files changed

// File: rtl/serial_pattern_checker_pkg.sv
// Shared FSM state encoding and default parameters for the serial pattern checker.
package pattern_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned     DEF_PAT_LEN    = 8;
  localparam logic [7:0]      DEF_PATTERN    = 8'hA6;
  localparam int unsigned     DEF_NUM_FRAMES = 4;
  localparam int unsigned     DEF_HUNT_MAX   = 64;
  localparam int unsigned     DEF_ERR_W      = 4;

endpackage

// File: rtl/serial_pattern_checker_if.sv
// Stream-in / status-out bundle between a stimulus source and the pattern checker.
import pattern_check_pkg::*;

interface serial_pattern_checker_if #(
  parameter int unsigned ERR_W = DEF_ERR_W
);
  logic             start;
  logic             din;
  logic             din_valid;
  logic             busy;
  logic             locked;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [ERR_W-1:0] err_count;

  modport master (
    output start, din, din_valid,
    input  busy, locked, done, pass, timeout, err_count
  );

  modport slave (
    input  start, din, din_valid,
    output busy, locked, done, pass, timeout, err_count
  );
endinterface

// File: rtl/serial_pattern_checker_shift_window.sv
// PAT_LEN-bit serial shift window with a saturating fill counter.
import pattern_check_pkg::*;

module shift_window #(
  parameter int unsigned PAT_LEN = DEF_PAT_LEN
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               din,
  output logic [PAT_LEN-1:0] window,
  output logic               full,
  output logic               almost_full
);
  localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

  logic [FILL_W-1:0] fill;

  assign full        = (fill == FILL_W'(PAT_LEN));
  assign almost_full = (fill == FILL_W'(PAT_LEN - 1));

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= {window[PAT_LEN-2:0], din};
      if (!full) fill <= fill + FILL_W'(1);
    end
  end
endmodule

// File: rtl/serial_pattern_checker.sv
// Hunts a serial stream for PATTERN, then checks NUM_FRAMES repetitions bit by bit.
import pattern_check_pkg::*;

module serial_pattern_checker #(
  parameter int unsigned         PAT_LEN    = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]  PATTERN    = DEF_PATTERN,
  parameter int unsigned         NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int unsigned         HUNT_MAX   = DEF_HUNT_MAX,
  parameter int unsigned         ERR_W      = DEF_ERR_W
) (
  input  logic clk,
  input  logic clr,
  serial_pattern_checker_if.slave bus
);
  localparam int unsigned HUNT_W = $clog2(HUNT_MAX + 1);
  localparam int unsigned IDX_W  = $clog2(PAT_LEN);
  localparam int unsigned FRM_W  = $clog2(NUM_FRAMES + 1);

  state_t              state;
  logic [HUNT_W-1:0]   hunt_cnt;
  logic [IDX_W-1:0]    bit_idx;
  logic [FRM_W-1:0]    frame;
  logic [ERR_W-1:0]    err;
  logic                busy, locked, done, pass, timeout;

  logic [PAT_LEN-1:0]  window;
  logic                full, almost_full;
  logic                shift_en, sw_clear;
  logic                hdr_match, exp_bit, last_bit;
  logic [ERR_W-1:0]    err_next;

  assign shift_en = (state == HUNT) && bus.din_valid;
  assign sw_clear = (state == IDLE) && bus.start;

  shift_window #(.PAT_LEN(PAT_LEN)) u_window (
    .clk         (clk),
    .clr         (clr),
    .clear       (sw_clear),
    .shift_en    (shift_en),
    .din         (bus.din),
    .window      (window),
    .full        (full),
    .almost_full (almost_full)
  );

  // Header compare looks at the window as it will be after this bit shifts in.
  always_comb begin
    hdr_match = (full || almost_full) && ({window[PAT_LEN-2:0], bus.din} == PATTERN);
    exp_bit   = PATTERN[IDX_W'(PAT_LEN - 1) - bit_idx];
    err_next  = err;
    if ((bus.din != exp_bit) && (err != '1)) err_next = err + ERR_W'(1);
    last_bit  = (bit_idx == IDX_W'(PAT_LEN - 1)) && (frame == FRM_W'(NUM_FRAMES - 1));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      hunt_cnt <= '0;
      bit_idx  <= '0;
      frame    <= '0;
      err      <= '0;
      busy     <= 1'b0;
      locked   <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            locked   <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            err      <= '0;
            hunt_cnt <= '0;
            busy     <= 1'b1;
            state    <= HUNT;
          end
        end
        HUNT: begin
          if (bus.din_valid) begin
            hunt_cnt <= hunt_cnt + HUNT_W'(1);
            if (hdr_match) begin
              locked  <= 1'b1;
              bit_idx <= '0;
              frame   <= '0;
              state   <= CHECK;
            end else if (hunt_cnt == HUNT_W'(HUNT_MAX - 1)) begin
              timeout <= 1'b1;
              pass    <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        CHECK: begin
          if (bus.din_valid) begin
            err <= err_next;
            if (last_bit) begin
              pass  <= locked && !timeout && (err_next == '0);
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else if (bit_idx == IDX_W'(PAT_LEN - 1)) begin
              bit_idx <= '0;
              frame   <= frame + FRM_W'(1);
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.locked    = locked;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.timeout   = timeout;
  assign bus.err_count = err;
endmodule
